// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity serial framer:
//   tx_state_t  - framer FSM states (IDLE/START/DATA/PARITY/STOP)
//   IDLE_LEVEL  - serial line level when idle and during the stop bit
//   START_LEVEL - serial line level during the start bit
//   exp_parity  - expected parity of a data word (even or odd sense)
// -----------------------------------------------------------------------------
package parity_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Widest data word exp_parity accepts. Callers zero-extend narrower words;
  // zero bits do not change the XOR reduction.
  localparam int PAR_MAX_W = 64;

  // Even sense: ^data. Odd sense: ~^data.
  function automatic logic exp_parity(input logic [PAR_MAX_W-1:0] data,
                                      input logic                 odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_baud_tick.sv
// -----------------------------------------------------------------------------
// parity_baud_tick
// Bit-period divider for the framer. Counts 0..CLKS_PER_BIT-1 while enabled
// and flags the last clock of every bit period.
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_clear  in   restart the bit period (asserted on word acceptance)
//   i_en     in   count enable (frame in progress)
//   o_tick   out  high during the last clock of each bit period
// -----------------------------------------------------------------------------
module parity_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_LAST);

  // Tick is combinational so the FSM changes state on the very edge that
  // closes the bit period.
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/parity_frame_tx.sv
// -----------------------------------------------------------------------------
// parity_frame_tx
// Serial framer behind the even-parity generator. Accepts a data word plus its
// parity bit, flags a parity mismatch, then sends start bit, data LSB-first,
// the supplied parity bit and a stop bit, each held CLKS_PER_BIT clocks.
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   in_valid      in   word and parity present
//   in_ready      out  block can accept a word (state == IDLE)
//   in_data       in   data word [DATA_W-1:0]
//   in_parity     in   parity bit, transmitted unchanged
//   tx            out  serial line, idle high
//   busy          out  frame in progress
//   frame_done    out  one-cycle pulse in the first IDLE cycle after a frame
//   par_mismatch  out  one-cycle pulse, first START cycle, if parity is wrong
//   dbg_state     out  current FSM state
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// Upstream holds in_data/in_parity stable until that edge; in_valid is
// ignored while a frame is in progress.
// -----------------------------------------------------------------------------
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 3,
  parameter int CLKS_PER_BIT = 4,
  parameter bit ODD          = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic              par_mismatch,
  output tx_state_t         dbg_state
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  tx_state_t         r_state;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              r_tx;
  logic              r_busy;
  logic              r_done;
  logic              r_mm;

  tx_state_t         w_state_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic              w_par_nxt;
  logic [BIT_W-1:0]  w_bit_cnt_nxt;
  logic              w_tx_nxt;
  logic              w_done_nxt;
  logic              w_mm_nxt;
  logic              w_accept;
  logic              w_tick;
  logic              w_running;

  assign w_accept  = in_valid && (r_state == IDLE);
  assign w_running = (r_state != IDLE);

  parity_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept),
    .i_en    (w_running),
    .o_tick  (w_tick)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_par_nxt     = r_par;
    w_bit_cnt_nxt = r_bit_cnt;
    w_done_nxt    = 1'b0;
    w_mm_nxt      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt   = START;
          w_shift_nxt   = in_data;
          w_par_nxt     = in_parity;
          w_bit_cnt_nxt = '0;
          w_mm_nxt      = (in_parity != exp_parity(PAR_MAX_W'(in_data), ODD));
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt   = DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == BIT_LAST) begin
            w_state_nxt = PARITY;
          end else begin
            w_shift_nxt   = r_shift >> 1;
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Line level is decoded from the next state so tx is registered yet
  // changes on the same edge as the state.
  always_comb begin
    w_tx_nxt = IDLE_LEVEL;
    unique case (w_state_nxt)
      START:   w_tx_nxt = START_LEVEL;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      PARITY:  w_tx_nxt = w_par_nxt;
      default: w_tx_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_cnt <= '0;
      r_tx      <= IDLE_LEVEL;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mm      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_par     <= w_par_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
      r_mm      <= w_mm_nxt;
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign tx           = r_tx;
  assign busy         = r_busy;
  assign frame_done   = r_done;
  assign par_mismatch = r_mm;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_parity_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_tx
// Directed bench for parity_frame_tx: a default instance (DATA_W=3,
// CLKS_PER_BIT=4, even) and a wide instance (DATA_W=8, CLKS_PER_BIT=1, odd).
// Expected line sequences are written out by hand, first bit on the line in
// the leftmost (MSB) position of each constant.
// -----------------------------------------------------------------------------
module tb_parity_frame_tx;
  import parity_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- default instance ----------------
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic       in_parity;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       par_mismatch;
  tx_state_t  dbg_state;

  parity_frame_tx #(
    .DATA_W       (3),
    .CLKS_PER_BIT (4),
    .ODD          (1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_parity    (in_parity),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done),
    .par_mismatch (par_mismatch),
    .dbg_state    (dbg_state)
  );

  // ---------------- wide instance ----------------
  logic       w8_valid;
  logic       w8_ready;
  logic [7:0] w8_data;
  logic       w8_parity;
  logic       w8_tx;
  logic       w8_busy;
  logic       w8_done;
  logic       w8_mm;
  tx_state_t  w8_state;

  parity_frame_tx #(
    .DATA_W       (8),
    .CLKS_PER_BIT (1),
    .ODD          (1'b1)
  ) dut_w8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (w8_valid),
    .in_ready     (w8_ready),
    .in_data      (w8_data),
    .in_parity    (w8_parity),
    .tx           (w8_tx),
    .busy         (w8_busy),
    .frame_done   (w8_done),
    .par_mismatch (w8_mm),
    .dbg_state    (w8_state)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  // Per-cycle capture of the default instance, index 0 = first cycle after
  // the acceptance edge.
  logic cap_tx   [64];
  logic cap_busy [64];
  logic cap_rdy  [64];
  logic cap_done [64];
  logic cap_mm   [64];

  // Samples the current cycle, then advances to 1 time unit after the next
  // rising edge. Called right after an acceptance edge.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx[i]   = tx;
      cap_busy[i] = busy;
      cap_rdy[i]  = in_ready;
      cap_done[i] = frame_done;
      cap_mm[i]   = par_mismatch;
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a word and returns 1 unit after its acceptance edge.
  task automatic send_word(input logic [2:0] d, input logic p, input logic keep_valid);
    in_data   = d;
    in_parity = p;
    in_valid  = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1)
      $display("FAIL ready_before_accept: got %b expected 1", in_ready);
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_parity = 1'b0;
    w8_valid  = 1'b0;
    w8_data   = '0;
    w8_parity = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({tx, busy, in_ready, frame_done, par_mismatch} !== 5'b10100) begin
      n_fail++;
      $display("FAIL reset_outputs: got tx,busy,rdy,done,mm=%b expected 10100",
               {tx, busy, in_ready, frame_done, par_mismatch});
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    n_cmp++;
    if ({w8_tx, w8_busy, w8_ready} !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_w8: got tx,busy,rdy=%b expected 101", {w8_tx, w8_busy, w8_ready});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({tx, busy, in_ready, frame_done, par_mismatch} !== 5'b10100) begin
        n_fail++;
        $display("FAIL idle_cycle_%0d: got tx,busy,rdy,done,mm=%b expected 10100",
                 i, {tx, busy, in_ready, frame_done, par_mismatch});
      end
    end
  endtask

  task automatic test_single_frame();
    logic [5:0] exp_line;
    exp_line = 6'b010101;  // 101 p=0: start 0, d0=1, d1=0, d2=1, par 0, stop 1
    send_word(3'b101, 1'b0, 1'b0);
    capture(26);
    for (int i = 0; i < 24; i++) begin
      n_cmp++;
      if (cap_tx[i] !== exp_line[5 - i / 4]) begin
        n_fail++;
        $display("FAIL single_tx_%0d: got %b expected %b", i, cap_tx[i], exp_line[5 - i / 4]);
      end
      n_cmp++;
      if ({cap_busy[i], cap_rdy[i], cap_done[i], cap_mm[i]} !== 4'b1000) begin
        n_fail++;
        $display("FAIL single_flags_%0d: got busy,rdy,done,mm=%b expected 1000",
                 i, {cap_busy[i], cap_rdy[i], cap_done[i], cap_mm[i]});
      end
    end
    n_cmp++;
    if ({cap_tx[24], cap_busy[24], cap_rdy[24], cap_done[24]} !== 4'b1011) begin
      n_fail++;
      $display("FAIL single_done: got tx,busy,rdy,done=%b expected 1011",
               {cap_tx[24], cap_busy[24], cap_rdy[24], cap_done[24]});
    end
    n_cmp++;
    if ({cap_tx[25], cap_busy[25], cap_rdy[25], cap_done[25], cap_mm[25]} !== 5'b10100) begin
      n_fail++;
      $display("FAIL single_after: got tx,busy,rdy,done,mm=%b expected 10100",
               {cap_tx[25], cap_busy[25], cap_rdy[25], cap_done[25], cap_mm[25]});
    end
  endtask

  task automatic test_parity_error();
    logic [5:0] exp_line;
    exp_line = 6'b001111;  // 110 p=1: start 0, d0=0, d1=1, d2=1, par 1, stop 1
    send_word(3'b110, 1'b1, 1'b0);
    capture(26);
    n_cmp++;
    if (cap_mm[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_pulse: got %b expected 1", cap_mm[0]);
    end
    for (int i = 1; i < 26; i++) begin
      n_cmp++;
      if (cap_mm[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL perr_pulse_len_%0d: got %b expected 0", i, cap_mm[i]);
      end
    end
    for (int i = 0; i < 24; i++) begin
      n_cmp++;
      if (cap_tx[i] !== exp_line[5 - i / 4]) begin
        n_fail++;
        $display("FAIL perr_tx_%0d: got %b expected %b", i, cap_tx[i], exp_line[5 - i / 4]);
      end
    end
    n_cmp++;
    if ({cap_done[23], cap_done[24], cap_busy[24]} !== 3'b010) begin
      n_fail++;
      $display("FAIL perr_done: got done23,done24,busy24=%b expected 010",
               {cap_done[23], cap_done[24], cap_busy[24]});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_a;
    logic [5:0] exp_b;
    exp_a = 6'b010011;  // 001 p=1
    exp_b = 6'b011111;  // 111 p=1
    send_word(3'b001, 1'b1, 1'b1);
    // Second word waits with in_valid held high through the whole first frame.
    in_data   = 3'b111;
    in_parity = 1'b1;
    capture(25);
    for (int i = 0; i < 24; i++) begin
      n_cmp++;
      if (cap_tx[i] !== exp_a[5 - i / 4]) begin
        n_fail++;
        $display("FAIL b2b_a_tx_%0d: got %b expected %b", i, cap_tx[i], exp_a[5 - i / 4]);
      end
      n_cmp++;
      if ({cap_busy[i], cap_rdy[i], cap_done[i]} !== 3'b100) begin
        n_fail++;
        $display("FAIL b2b_a_flags_%0d: got busy,rdy,done=%b expected 100",
                 i, {cap_busy[i], cap_rdy[i], cap_done[i]});
      end
    end
    n_cmp++;
    if ({cap_tx[24], cap_busy[24], cap_rdy[24], cap_done[24]} !== 4'b1011) begin
      n_fail++;
      $display("FAIL b2b_gap: got tx,busy,rdy,done=%b expected 1011",
               {cap_tx[24], cap_busy[24], cap_rdy[24], cap_done[24]});
    end
    // Second word was accepted on the edge closing the frame_done cycle.
    in_valid = 1'b0;
    capture(26);
    for (int i = 0; i < 24; i++) begin
      n_cmp++;
      if (cap_tx[i] !== exp_b[5 - i / 4]) begin
        n_fail++;
        $display("FAIL b2b_b_tx_%0d: got %b expected %b", i, cap_tx[i], exp_b[5 - i / 4]);
      end
    end
    n_cmp++;
    if ({cap_busy[0], cap_mm[0], cap_done[23], cap_done[24], cap_done[25]} !== 5'b10010) begin
      n_fail++;
      $display("FAIL b2b_b_flags: got busy0,mm0,done23,done24,done25=%b expected 10010",
               {cap_busy[0], cap_mm[0], cap_done[23], cap_done[24], cap_done[25]});
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [5:0] exp_line;
    exp_line = 6'b011001;  // 011 p=0
    send_word(3'b010, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    // Inside the first data bit period; d0 of 010 is 0.
    n_cmp++;
    if ({dbg_state, tx, busy} !== {DATA, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_pre: got state,tx,busy=%b expected %b",
               {dbg_state, tx, busy}, {DATA, 1'b0, 1'b1});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx, busy, in_ready, frame_done} !== 4'b1010) begin
      n_fail++;
      $display("FAIL mid_async: got tx,busy,rdy,done=%b expected 1010",
               {tx, busy, in_ready, frame_done});
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL mid_state: got %0d expected %0d", dbg_state, IDLE);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({tx, busy, frame_done} !== 3'b100) begin
        n_fail++;
        $display("FAIL mid_quiet_%0d: got tx,busy,done=%b expected 100",
                 i, {tx, busy, frame_done});
      end
    end
    send_word(3'b011, 1'b0, 1'b0);
    capture(26);
    for (int i = 0; i < 24; i++) begin
      n_cmp++;
      if (cap_tx[i] !== exp_line[5 - i / 4]) begin
        n_fail++;
        $display("FAIL mid_new_tx_%0d: got %b expected %b", i, cap_tx[i], exp_line[5 - i / 4]);
      end
    end
    n_cmp++;
    if ({cap_mm[0], cap_done[23], cap_done[24]} !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_new_flags: got mm0,done23,done24=%b expected 001",
               {cap_mm[0], cap_done[23], cap_done[24]});
    end
  endtask

  task automatic test_param_sweep();
    logic [10:0] exp_line;
    exp_line  = 11'b01010010111;  // A5 LSB-first, odd parity 1, stop 1
    w8_data   = 8'hA5;
    w8_parity = 1'b1;
    w8_valid  = 1'b1;
    n_cmp++;
    if (w8_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL w8_ready: got %b expected 1", w8_ready);
    end
    @(posedge clk);
    #1;
    w8_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      n_cmp++;
      if (w8_tx !== exp_line[10 - i]) begin
        n_fail++;
        $display("FAIL w8_tx_%0d: got %b expected %b", i, w8_tx, exp_line[10 - i]);
      end
      n_cmp++;
      if ({w8_busy, w8_done, w8_mm} !== 3'b100) begin
        n_fail++;
        $display("FAIL w8_flags_%0d: got busy,done,mm=%b expected 100",
                 i, {w8_busy, w8_done, w8_mm});
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({w8_tx, w8_busy, w8_ready, w8_done, w8_mm} !== 5'b10110) begin
      n_fail++;
      $display("FAIL w8_done: got tx,busy,rdy,done,mm=%b expected 10110",
               {w8_tx, w8_busy, w8_ready, w8_done, w8_mm});
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_parity_error();
    test_back_to_back();
    test_mid_frame_reset();
    test_param_sweep();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, expected finish well before", $time);
    $fatal(1);
  end

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Serial framer sitting directly downstream of the 3-bit even-parity generator. It accepts a parallel data word together with its generated parity bit over a valid/ready handshake. It recomputes parity to flag mismatches, then shifts out a UART-style frame: start bit, data LSB-first, the supplied parity bit, and a stop bit. It feeds the board-level serial line.

## Interface
- DATA_W, 3, data word width; must be ≥ 1.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held; must be ≥ 1.
- ODD, 0, 0 = even parity (expected parity = ^data); 1 = odd (expected = ~^data).

- clk  input  1  single system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  word and parity present.
- in_ready  output  1  block can accept a word.
- in_data  input  DATA_W  data word.
- in_parity  input  1  parity bit from the upstream generator, transmitted as given.
- tx  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse when a frame completes.
- par_mismatch  output  1  one-cycle pulse when in_parity ≠ expected parity of the accepted in_data.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values: state=IDLE, tx=1, busy=0, frame_done=0, par_mismatch=0, in_ready=1. Counters and shift register are 0.
- in_ready = (state==IDLE). It is derived combinationally from state.
- Acceptance: a word is accepted on a rising edge with in_valid && in_ready. On that edge:
  - in_data is latched into the shift register and in_parity into a parity register.
  - The state goes to START.
  - par_mismatch is registered high for exactly one cycle if the parity is wrong.
- in_valid is ignored outside IDLE. Upstream holds data until acceptance.
- IDLE → START on acceptance.
- START → DATA after CLKS_PER_BIT cycles.
- DATA:
  - tx = shift[0].
  - Shift right every CLKS_PER_BIT cycles.
  - bit_cnt counts 0..DATA_W-1.
  - DATA → PARITY when the last bit's period expires.
- PARITY: tx = latched in_parity. Go to STOP after CLKS_PER_BIT cycles.
- STOP: tx=1. Go to IDLE after CLKS_PER_BIT cycles. frame_done pulses in the first IDLE cycle.
- Line value by state: tx=0 in START, tx=1 in IDLE and STOP.
- busy = (state≠IDLE).
- Mismatch does not abort the frame. The supplied parity bit is sent unchanged, so error injection propagates downstream.
- Counter widths:
  - baud_cnt: $clog2(CLKS_PER_BIT) bits, minimum 1. Wraps from CLKS_PER_BIT-1 to 0 and produces a bit tick.
  - bit_cnt: $clog2(DATA_W) bits, minimum 1.
  - No counter ever exceeds its terminal value.
- Reset mid-frame: tx returns to 1 and state to IDLE immediately (asynchronously). The partial frame is abandoned and no frame_done is issued.

## Timing
- tx goes low on the first clock edge after acceptance; the START bit begins there.
- Frame length: (DATA_W+3)·CLKS_PER_BIT cycles from the acceptance edge to the STOP→IDLE edge. The default is 24 cycles.
- frame_done and in_ready are both high in the first IDLE cycle.
- A word accepted in that same cycle starts the next START one edge later.
- Minimum inter-frame gap: one cycle of tx=1 beyond the stop bit.
- par_mismatch is asserted in the cycle after the acceptance edge, coincident with the first START cycle.
- All outputs are registered except in_ready.

## Structure
- Shared package parity_pkg contains:
  - tx_state_t, the state enum IDLE/START/DATA/PARITY/STOP.
  - The parity function exp_parity(data, odd).
  - Constants IDLE_LEVEL=1 and START_LEVEL=0.
- One sub-module, parity_baud_tick. It is the CLKS_PER_BIT divider, with a clear input asserted on acceptance, and it outputs a one-cycle tick. The FSM, shift register and bit counter stay in parity_frame_tx.

## Test plan
- Reset then idle: hold rst_n=0 for 3 cycles, then release with in_valid=0 for 10 cycles → tx=1, busy=0, in_ready=1, no pulses.
- Single frame, defaults: in_data=3'b101, in_parity=0 →
  - tx sequence (4 cycles each) is 0,1,0,1,0,1.
  - frame_done pulses exactly 24 cycles after acceptance.
  - par_mismatch stays 0.
- Parity error: in_data=3'b110, in_parity=1 →
  - par_mismatch pulses for one cycle, in the cycle after acceptance.
  - Transmitted parity bit = 1.
  - The frame completes normally.
- Back-to-back: in_valid held high with 3'b001/p=1, then 3'b111/p=1 →
  - The second acceptance happens in the frame_done cycle.
  - The gap is exactly one tx=1 cycle beyond the stop bit.
  - in_valid asserted during the first frame is ignored.
- Mid-frame reset: assert rst_n=0 during the DATA state of frame 3'b010 →
  - tx=1 and busy=0 in the same cycle, with no frame_done.
  - After release, a new frame with 3'b011/p=0 transmits correctly.
- Parameter sweep: DATA_W=8, CLKS_PER_BIT=1, ODD=1, in_data=8'hA5, in_parity=1 →
  - Frame of 11 cycles: 0, 1,0,1,0,0,1,0,1, 1, 1.
  - No mismatch.
